// File: rtl/car_controller_if.sv
// Request/acknowledge bundle between the button request register and the
// car controller.
//   active_*      : pending requests, driven by the request register
//   inactivate_*  : one-cycle clear pulses, driven by the car controller
// Hall-up calls exist on floors 0..BUTTONS_WIDTH-2.
// Hall-down calls exist on floors 1..BUTTONS_WIDTH-1.
interface car_controller_if #(
  parameter int BUTTONS_WIDTH = 8
);
  logic [BUTTONS_WIDTH-1:0] active_in_levels;
  logic [BUTTONS_WIDTH-2:0] active_out_up_levels;
  logic [BUTTONS_WIDTH-1:1] active_out_down_levels;
  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
  logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels;
  logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels;

  // Request register side.
  modport master (
    output active_in_levels, active_out_up_levels, active_out_down_levels,
    input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels
  );

  // Car controller side.
  modport slave (
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
    output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels
  );
endinterface

// File: rtl/car_controller.sv
// Single-car elevator motion and door controller (collective SCAN).
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-low
//   req_if        : request levels in, one-cycle clear pulses out
//   current_floor : floor the car is at or last passed
//   dir_up        : committed direction (1 = up, 0 = down)
//   moving        : car travelling between floors
//   door_open     : door open at current_floor
module car_controller #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int MOVE_CYCLES   = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic            clock,
  input  logic            reset,
  car_controller_if.slave req_if,
  output logic [3:0]      current_floor,
  output logic            dir_up,
  output logic            moving,
  output logic            door_open
);
  localparam int BW  = BUTTONS_WIDTH;
  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     floor_q, floor_d;
  logic           dir_up_q, dir_up_d;
  logic [MCW-1:0] move_cnt_q, move_cnt_d;
  logic [DCW-1:0] door_cnt_q, door_cnt_d;
  logic [BW-1:0]  pin_q, pin_d, pup_q, pup_d, pdn_q, pdn_d;

  // Hall vectors widened to full floor range; the missing ends read as 0.
  logic [BW-1:0]  in_x, up_x, dn_x, req;
  logic [BW-1:0]  at_n, above_vec, below_vec;
  logic [BW-1:0]  svc_in, svc_up, svc_dn, hold_in, hold_hall;
  logic [3:0]     n_floor;
  logic           above, below, any_req, move_done, stop_up, stop_dn, svc_flip;

  assign in_x = req_if.active_in_levels;
  assign up_x = {1'b0, req_if.active_out_up_levels};
  assign dn_x = {req_if.active_out_down_levels, 1'b0};
  assign req  = in_x | up_x | dn_x;

  assign move_done = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) &&
                     (move_cnt_q == MCW'(MOVE_CYCLES - 1));

  // All floor-relative terms are evaluated at the floor the car will occupy
  // after this edge, so an arrival is judged against the new floor and
  // requests that change on the terminal cycle are taken into account.
  always_comb begin
    n_floor = floor_q;
    if (move_done) begin
      n_floor = (state_q == MOVE_UP) ? floor_q + 4'd1 : floor_q - 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_floor
      assign at_n[gi]      = (n_floor == 4'(gi));
      assign above_vec[gi] = req[gi] & (4'(gi) > n_floor);
      assign below_vec[gi] = req[gi] & (4'(gi) < n_floor);
    end
  endgenerate

  assign above   = |above_vec;
  assign below   = |below_vec;
  assign any_req = |req;

  // A hall call against the travel direction only stops the car when it is
  // the last request in that direction; the end floors always stop.
  assign stop_up = (|((in_x | up_x) & at_n)) | ((|(dn_x & at_n)) & ~above) |
                   (n_floor == 4'(BW - 1));
  assign stop_dn = (|((in_x | dn_x) & at_n)) | ((|(up_x & at_n)) & ~below) |
                   (n_floor == 4'd0);

  // Service at n_floor: clear the in-car call and the same-direction hall
  // call; when nothing lies further ahead, also clear the opposite hall call
  // and reverse.
  always_comb begin
    svc_in   = in_x & at_n;
    svc_up   = '0;
    svc_dn   = '0;
    svc_flip = 1'b0;
    if (dir_up_q) begin
      svc_up = up_x & at_n;
      if (!above) begin
        svc_dn   = dn_x & at_n;
        svc_flip = 1'b1;
      end
    end else begin
      svc_dn = dn_x & at_n;
      if (!below) begin
        svc_up   = up_x & at_n;
        svc_flip = 1'b1;
      end
    end
  end

  // Door-hold candidates. A bit currently being pulsed is masked because the
  // request register only drops it at the end of the pulse cycle.
  assign hold_in   = in_x & at_n & ~pin_q;
  assign hold_hall = dir_up_q ? (up_x & at_n & ~pup_q) : (dn_x & at_n & ~pdn_q);

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    pin_d      = '0;
    pup_d      = '0;
    pdn_d      = '0;
    case (state_q)
      IDLE: begin
        move_cnt_d = '0;
        door_cnt_d = '0;
        if (|(req & at_n)) begin
          state_d  = DOOR_OPEN;
          pin_d    = svc_in;
          pup_d    = svc_up;
          pdn_d    = svc_dn;
          dir_up_d = dir_up_q ^ svc_flip;
        end else if (dir_up_q && above) begin
          state_d = MOVE_UP;
        end else if (!dir_up_q && below) begin
          state_d = MOVE_DOWN;
        end else if (above) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (!move_done) begin
          move_cnt_d = move_cnt_q + 1'b1;
        end else begin
          floor_d    = n_floor;
          move_cnt_d = '0;
          if ((state_q == MOVE_UP) ? stop_up : stop_dn) begin
            state_d    = DOOR_OPEN;
            door_cnt_d = '0;
            pin_d      = svc_in;
            pup_d      = svc_up;
            pdn_d      = svc_dn;
            dir_up_d   = dir_up_q ^ svc_flip;
          end else if (!any_req) begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if ((|hold_in) || (|hold_hall)) begin
          pin_d      = hold_in;
          door_cnt_d = '0;
          if (dir_up_q) pup_d = hold_hall;
          else          pdn_d = hold_hall;
        end else if (door_cnt_q == DCW'(DOOR_CYCLES - 1)) begin
          state_d    = IDLE;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      dir_up_q   <= 1'b1;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
      pin_q      <= '0;
      pup_q      <= '0;
      pdn_q      <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
      pin_q      <= pin_d;
      pup_q      <= pup_d;
      pdn_q      <= pdn_d;
    end
  end

  assign current_floor                     = floor_q;
  assign dir_up                            = dir_up_q;
  assign moving                            = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign door_open                         = (state_q == DOOR_OPEN);
  assign req_if.inactivate_in_levels       = pin_q;
  assign req_if.inactivate_out_up_levels   = pup_q[BW-2:0];
  assign req_if.inactivate_out_down_levels = pdn_q[BW-1:1];
endmodule

// File: tb/tb_car_controller.sv
// Directed testbench for car_controller. The bench plays the request
// register: levels set by the tests are cleared on the edge that ends an
// inactivate pulse.
module tb_car_controller;
  localparam int BW = 8;
  localparam int MC = 4;
  localparam int DC = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] current_floor;
  logic       dir_up, moving, door_open;

  car_controller_if #(.BUTTONS_WIDTH(BW)) ifc();

  car_controller #(.BUTTONS_WIDTH(BW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .req_if(ifc),
    .current_floor(current_floor), .dir_up(dir_up),
    .moving(moving), .door_open(door_open)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  logic [7:0] act_in, prev_in;
  logic [6:0] act_up, prev_up;
  logic [7:1] act_dn, prev_dn;
  int pc_in[8];
  int pc_up[8];
  int pc_dn[8];

  task automatic apply();
    ifc.active_in_levels       = act_in;
    ifc.active_out_up_levels   = act_up;
    ifc.active_out_down_levels = act_dn;
  endtask

  // One clock: tally pulses of the ending cycle, note protocol violations,
  // then clear acknowledged requests as the request register would.
  task automatic step();
    logic [7:0] pi;
    logic [6:0] pu;
    logic [7:1] pd;
    pi = ifc.inactivate_in_levels;
    pu = ifc.inactivate_out_up_levels;
    pd = ifc.inactivate_out_down_levels;
    if (((pi & ~act_in) != 0) || ((pu & ~act_up) != 0) || ((pd & ~act_dn) != 0)) viol++;
    if (((pi & prev_in) != 0) || ((pu & prev_up) != 0) || ((pd & prev_dn) != 0)) viol++;
    prev_in = pi;
    prev_up = pu;
    prev_dn = pd;
    for (int i = 0; i < 8; i++) if (pi[i]) pc_in[i]++;
    for (int i = 0; i < 7; i++) if (pu[i]) pc_up[i]++;
    for (int i = 1; i < 8; i++) if (pd[i]) pc_dn[i]++;
    @(posedge clock);
    #1;
    act_in = act_in & ~pi;
    act_up = act_up & ~pu;
    act_dn = act_dn & ~pd;
    apply();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < 8; i++) s += pc_in[i] + pc_up[i] + pc_dn[i];
    return s;
  endfunction

  // Two edges in reset, release 1 time unit after an edge, requests cleared.
  task automatic do_reset();
    reset = 1'b0;
    act_in = '0; act_up = '0; act_dn = '0;
    prev_in = '0; prev_up = '0; prev_dn = '0;
    apply();
    for (int i = 0; i < 8; i++) begin pc_in[i] = 0; pc_up[i] = 0; pc_dn[i] = 0; end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    act_in = 8'hFF; act_up = '1; act_dn = '1;
    apply();
    @(posedge clock); #1;
    @(posedge clock); #1;
    tests++; if (current_floor !== 4'd0) begin fails++; $display("FAIL reset_floor: got %0d want 0", current_floor); end
    tests++; if (dir_up !== 1'b1) begin fails++; $display("FAIL reset_dir: got %b want 1", dir_up); end
    tests++; if ({moving, door_open} !== 2'b00) begin fails++; $display("FAIL reset_motion: got moving=%b door=%b want 0 0", moving, door_open); end
    tests++; if ({ifc.inactivate_in_levels, ifc.inactivate_out_up_levels, ifc.inactivate_out_down_levels} !== 22'd0) begin
      fails++; $display("FAIL reset_pulses: got in=%h up=%h dn=%h want 0", ifc.inactivate_in_levels, ifc.inactivate_out_up_levels, ifc.inactivate_out_down_levels); end
    do_reset();
    step();
    tests++; if ({moving, door_open, current_floor} !== 6'd0) begin fails++; $display("FAIL reset_idle: got moving=%b door=%b floor=%0d want idle at 0", moving, door_open, current_floor); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    act_in = 8'b0000_1000; apply();
    step();
    tests++; if ({moving, current_floor} !== {1'b1, 4'd0}) begin fails++; $display("FAIL basic_start: got moving=%b floor=%0d want 1 0", moving, current_floor); end
    step_n(11);
    tests++; if ({moving, current_floor} !== {1'b1, 4'd2}) begin fails++; $display("FAIL basic_floor2: got moving=%b floor=%0d want 1 2", moving, current_floor); end
    step();
    tests++; if ({door_open, moving, current_floor} !== {2'b10, 4'd3}) begin fails++; $display("FAIL basic_arrive: got door=%b moving=%b floor=%0d want 1 0 3", door_open, moving, current_floor); end
    tests++; if (ifc.inactivate_in_levels !== 8'b0000_1000) begin fails++; $display("FAIL basic_pulse: got %b want 00001000", ifc.inactivate_in_levels); end
    step();
    tests++; if ({door_open, ifc.inactivate_in_levels} !== {1'b1, 8'h00}) begin fails++; $display("FAIL basic_pulse_end: got door=%b in=%b want 1 00000000", door_open, ifc.inactivate_in_levels); end
    step_n(14);
    tests++; if (door_open !== 1'b1) begin fails++; $display("FAIL basic_door_held: got %b want 1", door_open); end
    step();
    tests++; if ({door_open, moving, dir_up} !== 3'b000) begin fails++; $display("FAIL basic_idle: got door=%b moving=%b dir=%b want 0 0 0", door_open, moving, dir_up); end
    tests++; if ((pc_in[3] !== 1) || (total_pulses() !== 1)) begin fails++; $display("FAIL basic_count: got in3=%0d total=%0d want 1 1", pc_in[3], total_pulses()); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_scan_stop();
    do_reset();
    act_in = 8'b0010_0000; act_up = 7'b000_0100; apply();
    step_n(9);
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd2, 1'b1}) begin fails++; $display("FAIL scan_stop2: got door=%b floor=%0d dir=%b want 1 2 1", door_open, current_floor, dir_up); end
    tests++; if ({ifc.inactivate_out_up_levels, ifc.inactivate_in_levels} !== {7'b000_0100, 8'h00}) begin
      fails++; $display("FAIL scan_pulse2: got up=%b in=%b want 0000100 00000000", ifc.inactivate_out_up_levels, ifc.inactivate_in_levels); end
    step_n(16);
    tests++; if ({door_open, moving} !== 2'b00) begin fails++; $display("FAIL scan_idle2: got door=%b moving=%b want 0 0", door_open, moving); end
    step();
    tests++; if (moving !== 1'b1) begin fails++; $display("FAIL scan_resume: got %b want 1", moving); end
    step_n(12);
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd5, 1'b0}) begin fails++; $display("FAIL scan_stop5: got door=%b floor=%0d dir=%b want 1 5 0", door_open, current_floor, dir_up); end
    tests++; if (ifc.inactivate_in_levels !== 8'b0010_0000) begin fails++; $display("FAIL scan_pulse5: got %b want 00100000", ifc.inactivate_in_levels); end
    step_n(16);
    tests++; if ((pc_up[2] !== 1) || (pc_in[5] !== 1) || (total_pulses() !== 2)) begin
      fails++; $display("FAIL scan_count: got up2=%0d in5=%0d total=%0d want 1 1 2", pc_up[2], pc_in[5], total_pulses()); end
    $display("[TB] test_scan_stop done");
  endtask

  task automatic test_reverse();
    logic [7:1] exp_dn;
    do_reset();
    act_dn = '0; act_dn[4] = 1'b1; act_in = 8'b0100_0000; apply();
    step_n(17);
    tests++; if ({moving, door_open, current_floor} !== {2'b10, 4'd4}) begin fails++; $display("FAIL rev_pass4: got moving=%b door=%b floor=%0d want 1 0 4", moving, door_open, current_floor); end
    step_n(8);
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd6, 1'b0}) begin fails++; $display("FAIL rev_stop6: got door=%b floor=%0d dir=%b want 1 6 0", door_open, current_floor, dir_up); end
    step_n(17);
    tests++; if ({moving, dir_up} !== 2'b10) begin fails++; $display("FAIL rev_down: got moving=%b dir=%b want 1 0", moving, dir_up); end
    step_n(8);
    exp_dn = '0; exp_dn[4] = 1'b1;
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd4, 1'b1}) begin fails++; $display("FAIL rev_stop4: got door=%b floor=%0d dir=%b want 1 4 1", door_open, current_floor, dir_up); end
    tests++; if (ifc.inactivate_out_down_levels !== exp_dn) begin fails++; $display("FAIL rev_pulse4: got %b want %b", ifc.inactivate_out_down_levels, exp_dn); end
    step_n(16);
    tests++; if ((pc_dn[4] !== 1) || (pc_in[6] !== 1) || (total_pulses() !== 2)) begin
      fails++; $display("FAIL rev_count: got dn4=%0d in6=%0d total=%0d want 1 1 2", pc_dn[4], pc_in[6], total_pulses()); end
    $display("[TB] test_reverse done");
  endtask

  task automatic test_top_floor();
    logic [7:1] exp_dn;
    do_reset();
    act_in = 8'b1000_0000; apply();
    step_n(29);
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd7, 1'b0}) begin fails++; $display("FAIL top_arrive: got door=%b floor=%0d dir=%b want 1 7 0", door_open, current_floor, dir_up); end
    step_n(16);
    tests++; if (door_open !== 1'b0) begin fails++; $display("FAIL top_idle: got %b want 0", door_open); end
    act_dn[7] = 1'b1; apply();
    step();
    exp_dn = '0; exp_dn[7] = 1'b1;
    tests++; if ({door_open, moving, current_floor} !== {2'b10, 4'd7}) begin fails++; $display("FAIL top_door: got door=%b moving=%b floor=%0d want 1 0 7", door_open, moving, current_floor); end
    tests++; if (ifc.inactivate_out_down_levels !== exp_dn) begin fails++; $display("FAIL top_pulse: got %b want %b", ifc.inactivate_out_down_levels, exp_dn); end
    step_n(16);
    tests++; if ((door_open !== 1'b0) || (pc_dn[7] !== 1) || (total_pulses() !== 2)) begin
      fails++; $display("FAIL top_count: got door=%b dn7=%0d total=%0d want 0 1 2", door_open, pc_dn[7], total_pulses()); end
    $display("[TB] test_top_floor done");
  endtask

  task automatic test_door_hold();
    do_reset();
    act_in = 8'b0100_1000; apply();
    step_n(13);
    tests++; if ({door_open, current_floor, dir_up} !== {1'b1, 4'd3, 1'b1}) begin fails++; $display("FAIL hold_arrive: got door=%b floor=%0d dir=%b want 1 3 1", door_open, current_floor, dir_up); end
    step_n(10);
    act_in[3] = 1'b1; apply();
    step();
    tests++; if ({door_open, ifc.inactivate_in_levels} !== {1'b1, 8'b0000_1000}) begin fails++; $display("FAIL hold_pulse: got door=%b in=%b want 1 00001000", door_open, ifc.inactivate_in_levels); end
    step();
    tests++; if (ifc.inactivate_in_levels !== 8'h00) begin fails++; $display("FAIL hold_pulse_end: got %b want 00000000", ifc.inactivate_in_levels); end
    step_n(14);
    tests++; if (door_open !== 1'b1) begin fails++; $display("FAIL hold_extended: got %b want 1", door_open); end
    step();
    tests++; if ({door_open, moving} !== 2'b00) begin fails++; $display("FAIL hold_close: got door=%b moving=%b want 0 0", door_open, moving); end
    step();
    tests++; if ({moving, pc_in[3]} !== {1'b1, 32'sd2}) begin fails++; $display("FAIL hold_resume: got moving=%b in3_pulses=%0d want 1 2", moving, pc_in[3]); end
    $display("[TB] test_door_hold done");
  endtask

  task automatic test_idle_priority();
    do_reset();
    act_in = 8'b0001_0001; apply();
    step();
    tests++; if ({door_open, moving, current_floor, dir_up} !== {2'b10, 4'd0, 1'b1}) begin
      fails++; $display("FAIL prio_door: got door=%b moving=%b floor=%0d dir=%b want 1 0 0 1", door_open, moving, current_floor, dir_up); end
    tests++; if (ifc.inactivate_in_levels !== 8'b0000_0001) begin fails++; $display("FAIL prio_pulse: got %b want 00000001", ifc.inactivate_in_levels); end
    $display("[TB] test_idle_priority done");
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    act_in = 8'b0010_0000; apply();
    step_n(10);
    tests++; if ({moving, current_floor} !== {1'b1, 4'd2}) begin fails++; $display("FAIL rmid_travel: got moving=%b floor=%0d want 1 2", moving, current_floor); end
    #2 reset = 1'b0;
    #1;
    tests++; if ({moving, door_open, dir_up, current_floor} !== {3'b001, 4'd0}) begin
      fails++; $display("FAIL rmid_async: got moving=%b door=%b dir=%b floor=%0d want 0 0 1 0", moving, door_open, dir_up, current_floor); end
    @(posedge clock); #1;
    reset = 1'b1;
    prev_in = '0; prev_up = '0; prev_dn = '0;
    step();
    tests++; if ({moving, current_floor} !== {1'b1, 4'd0}) begin fails++; $display("FAIL rmid_replan: got moving=%b floor=%0d want 1 0", moving, current_floor); end
    step_n(4);
    tests++; if (current_floor !== 4'd1) begin fails++; $display("FAIL rmid_floor1: got %0d want 1", current_floor); end
    $display("[TB] test_reset_mid_move done");
  endtask

  initial begin
    act_in = '0; act_up = '0; act_dn = '0;
    prev_in = '0; prev_up = '0; prev_dn = '0;
    apply();
    test_reset();
    test_basic();
    test_scan_stop();
    test_reverse();
    test_top_floor();
    test_door_hold();
    test_idle_priority();
    test_reset_mid_move();
    tests++; if (viol !== 0) begin fails++; $display("FAIL pulse_protocol: got %0d violations want 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
